xadc_drp_ctrl: RTL

Sequencer for the XADC dynamic reconfiguration port (DRP). On each end-of-conversion it reads the status register of the converted channel and presents a 12-bit sample. It also shares the DRP with a host configuration-write port, and flags overruns and DRP timeouts. It sits between the xadc_wiz instance and downstream sample consumers, in the XADC DCLK domain.

---
 rtl/xadc_drp_ctrl_if.sv | 23 ++
 rtl/xadc_drp_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/xadc_drp_ctrl_if.sv
// DRP bus between the sequencer (master) and the XADC primitive (slave).
// Latency: none, plain wires; timing is owned by the sequencer.
// Backpressure: the slave stalls the master by withholding drp_drdy_i.
// Ports: drp_den_o/drp_dwe_o/drp_daddr_o/drp_di_o are driven by the master;
//        drp_do_i/drp_drdy_i are returned by the slave.
interface xadc_drp_ctrl_if;
  logic        drp_den_o;
  logic        drp_dwe_o;
  logic [6:0]  drp_daddr_o;
  logic [15:0] drp_di_o;
  logic [15:0] drp_do_i;
  logic        drp_drdy_i;

  modport master (
    output drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o,
    input  drp_do_i, drp_drdy_i
  );

  modport slave (
    input  drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o,
    output drp_do_i, drp_drdy_i
  );
endinterface

// File: rtl/xadc_drp_ctrl.sv
// XADC DRP sequencer: status read per end-of-conversion, shared with host config writes.
// Latency: eoc -> den 1 cycle; drdy -> sample_valid_o / cfg_ack_o 1 cycle.
// Backpressure: one DRP access in flight; one eoc is buffered, further eocs set overrun_o.
// Ports: CLK100MHZ/reset_i clock and sync reset; eoc_i/channel_i from the XADC;
//        cfg_req_i/cfg_addr_i/cfg_data_i/cfg_ack_o host write handshake; drp DRP bus;
//        sample_o/sample_ch_o/sample_valid_o results; busy_o, overrun_o, timeout_o,
//        clr_flags_i status.
module xadc_drp_ctrl #(
  parameter logic [6:0] STATUS_BASE    = 7'h10,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic            CLK100MHZ,
  input  logic            reset_i,
  input  logic            eoc_i,
  input  logic [4:0]      channel_i,
  input  logic            cfg_req_i,
  input  logic [6:0]      cfg_addr_i,
  input  logic [15:0]     cfg_data_i,
  output logic            cfg_ack_o,
  xadc_drp_ctrl_if.master drp,
  output logic [11:0]     sample_o,
  output logic [4:0]      sample_ch_o,
  output logic            sample_valid_o,
  output logic            busy_o,
  output logic            overrun_o,
  output logic            timeout_o,
  input  logic            clr_flags_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t           state;
  logic             pend_flg;
  logic [4:0]       pend_ch;
  logic [4:0]       cur_ch;
  logic [CNT_W-1:0] tmo_cnt;

  // A fresh eoc in IDLE takes precedence over a buffered one.
  logic [4:0] sel_ch;
  logic [6:0] rd_addr;
  assign sel_ch  = eoc_i ? channel_i : pend_ch;
  assign rd_addr = STATUS_BASE + {2'b00, sel_ch};

  // Status registers carry the sample left-justified; the low nibble is unused.
  logic unused_do_bits;
  assign unused_do_bits = ^drp.drp_do_i[3:0];

  always_ff @(posedge CLK100MHZ) begin
    if (reset_i) begin
      state           <= IDLE;
      pend_flg        <= 1'b0;
      pend_ch         <= '0;
      cur_ch          <= '0;
      tmo_cnt         <= '0;
      cfg_ack_o       <= 1'b0;
      drp.drp_den_o   <= 1'b0;
      drp.drp_dwe_o   <= 1'b0;
      drp.drp_daddr_o <= '0;
      drp.drp_di_o    <= '0;
      sample_o        <= '0;
      sample_ch_o     <= '0;
      sample_valid_o  <= 1'b0;
      busy_o          <= 1'b0;
      overrun_o       <= 1'b0;
      timeout_o       <= 1'b0;
    end else begin
      drp.drp_den_o  <= 1'b0;
      drp.drp_dwe_o  <= 1'b0;
      sample_valid_o <= 1'b0;
      cfg_ack_o      <= 1'b0;

      // Set events are assigned after the clear so they win a same-cycle tie.
      if (clr_flags_i) begin
        overrun_o <= 1'b0;
        timeout_o <= 1'b0;
      end
      if (eoc_i && pend_flg) overrun_o <= 1'b1;

      // Buffer every eoc; IDLE clears the flag again when it launches directly.
      if (eoc_i) begin
        pend_flg <= 1'b1;
        pend_ch  <= channel_i;
      end

      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (eoc_i || pend_flg) begin
            state           <= RD_WAIT;
            busy_o          <= 1'b1;
            drp.drp_den_o   <= 1'b1;
            drp.drp_daddr_o <= rd_addr;
            cur_ch          <= sel_ch;
            pend_flg        <= 1'b0;
          end else if (cfg_req_i) begin
            state           <= WR_WAIT;
            busy_o          <= 1'b1;
            drp.drp_den_o   <= 1'b1;
            drp.drp_dwe_o   <= 1'b1;
            drp.drp_daddr_o <= cfg_addr_i;
            drp.drp_di_o    <= cfg_data_i;
          end
        end

        RD_WAIT: begin
          if (drp.drp_drdy_i) begin
            sample_o       <= drp.drp_do_i[15:4];
            sample_ch_o    <= cur_ch;
            sample_valid_o <= 1'b1;
            state          <= IDLE;
            busy_o         <= 1'b0;
          end else if (tmo_cnt == CNT_LAST) begin
            timeout_o <= 1'b1;
            state     <= IDLE;
            busy_o    <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        WR_WAIT: begin
          // An aborted write still acks so the host handshake always closes.
          if (drp.drp_drdy_i) begin
            cfg_ack_o <= 1'b1;
            state     <= IDLE;
            busy_o    <= 1'b0;
          end else if (tmo_cnt == CNT_LAST) begin
            cfg_ack_o <= 1'b1;
            timeout_o <= 1'b1;
            state     <= IDLE;
            busy_o    <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
